// File: rtl/score_pkg.sv
//------------------------------------------------------------------------------
// Module   : score_pkg
// Brief    : Shared widths and FSM state encoding for the score accumulator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package score_pkg;

  localparam int SCORE_W = 7;
  localparam int COUNT_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ADD  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/RCA.sv
//------------------------------------------------------------------------------
// Module   : RCA
// Brief    : N-bit combinational ripple-carry adder (sum and carry-out).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module RCA #(
  parameter int N = 7
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic carry;

  // Carry kept in a procedural variable so the chain is one ordered loop.
  always_comb begin
    carry = cin_i;
    sum_o = '0;
    for (int i = 0; i < N; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

`default_nettype wire

// File: rtl/score_accumulator.sv
//------------------------------------------------------------------------------
// Module   : score_accumulator
// Brief    : Handshaked unsigned accumulator on an RCA datapath with sticky
//            overflow and saturating item counter. Build option
//            SCORE_ACC_SATURATE_EN clamps the total to all ones on carry-out.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module score_accumulator
  import score_pkg::*;
#(
  parameter int N  = SCORE_W,
  parameter int CW = COUNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          clear,
  output logic [N-1:0]  acc_sum,
  output logic          acc_ovf,
  output logic          out_valid,
  output logic [CW-1:0] item_count
);

  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);

  state_e        state_q, state_d;
  logic [N-1:0]  op_q, op_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          ovf_q, ovf_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  w_rca_sum;
  logic          w_rca_cout;
  logic [N-1:0]  w_add_result;
  logic          w_accept;

  RCA #(.N(N)) u_rca (
    .a_i    (op_q),
    .b_i    (sum_q),
    .cin_i  (1'b0),
    .sum_o  (w_rca_sum),
    .cout_o (w_rca_cout)
  );

`ifdef SCORE_ACC_SATURATE_EN
  assign w_add_result = w_rca_cout ? {N{1'b1}} : w_rca_sum;
`else
  assign w_add_result = w_rca_sum;
`endif

  assign in_ready = !rst && (state_q == ST_IDLE) && !clear;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    if (clear) begin
      // Clear wins over everything, including an add already in flight.
      state_d = ST_IDLE;
      sum_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            op_d    = in_data;
            state_d = ST_ADD;
          end
        end
        ST_ADD: begin
          sum_d       = w_add_result;
          ovf_d       = ovf_q | w_rca_cout;
          cnt_d       = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + C_CNT_ONE;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign acc_sum    = sum_q;
  assign acc_ovf    = ovf_q;
  assign out_valid  = out_valid_q;
  assign item_count = cnt_q;

endmodule

`default_nettype wire
